// File: rtl/fpu_host_pkg.sv
// Shared constants and state encoding for the FPU host register-bus sequencer.
package fpu_host_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CMD_W      = 8;
  localparam int unsigned POLL_CNT_W = 8;
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_W);

  // Register map of the FPU software interface
  localparam logic [DATA_W-1:0] ADDR_CMD    = 32'h0000_0000;
  localparam logic [DATA_W-1:0] ADDR_OPA    = 32'h0000_0010;
  localparam logic [DATA_W-1:0] ADDR_OPB    = 32'h0000_0050;
  localparam logic [DATA_W-1:0] ADDR_STATUS = 32'h0000_0110;
  localparam logic [DATA_W-1:0] ADDR_RESULT = 32'h0000_0130;

  // Bit positions inside STATUS and CMD
  localparam int unsigned STATUS_DONE = 0;
  localparam int unsigned CMD_SRST    = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_CMD,
    S_GAP,
    S_POLL,
    S_GAP2,
    S_RD_RES,
    S_CLR,
    S_ABORT,
    S_RESP
  } state_e;

endpackage

// File: rtl/sw_read_port.sv
// Counts how long the read strobe has been held and qualifies the read data
// on the last cycle of the hold window.
module sw_read_port #(
  parameter int unsigned READ_LAT = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              data_valid_c,
  output logic [DATA_W-1:0] data_c
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hold counter restarts after the qualifying cycle or when the strobe drops
  always_comb begin
    cnt_d        = cnt_q;
    data_valid_c = rd_en && (cnt_q == CNT_W'(READ_LAT - 1));
    if (!rd_en || data_valid_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign data_c = rd_data;

  // Hold counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpu_host_sequencer.sv
// Runs one FPU job over the register bus: write operands and command, poll
// STATUS until done (or give up), read RESULT, clear done, return response.
module fpu_host_sequencer
  import fpu_host_pkg::*;
#(
  parameter int unsigned READ_LAT = 4,
  parameter int unsigned POLL_MAX = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_op_a,
  input  logic [DATA_W-1:0] req_op_b,
  input  logic [CMD_W-1:0]  req_cmd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_status,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [DATA_W-1:0] sw_address,
  output logic              sw_read_en,
  output logic              sw_write_en,
  output logic [DATA_W-1:0] sw_datain,
  input  logic [DATA_W-1:0] sw_dataout
);

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       a_q, a_d, b_q, b_d;
  logic [CMD_W-1:0]        cmd_q, cmd_d, cmd_wr;
  logic [POLL_CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [DATA_W-1:0]       status_clr;

  logic                    req_ready_q, req_ready_d;
  logic                    busy_q, busy_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_result_q, rsp_result_d;
  logic [DATA_W-1:0]       rsp_status_q, rsp_status_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    sw_read_en_q, sw_read_en_d;
  logic                    sw_write_en_q, sw_write_en_d;
  logic [DATA_W-1:0]       sw_address_q, sw_address_d;
  logic [DATA_W-1:0]       sw_datain_q, sw_datain_d;

  logic                    rd_last_c;
  logic [DATA_W-1:0]       rd_data_c;

  sw_read_port #(
    .READ_LAT (READ_LAT),
    .DATA_W   (DATA_W)
  ) u_read_port (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_en        (sw_read_en_q),
    .rd_data      (sw_dataout),
    .data_valid_c (rd_last_c),
    .data_c       (rd_data_c)
  );

  // Next state, job bookkeeping, and next values of every registered output
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    cmd_d         = cmd_q;
    poll_cnt_d    = poll_cnt_q;
    rsp_result_d  = rsp_result_q;
    rsp_status_d  = rsp_status_q;
    rsp_timeout_d = rsp_timeout_q;

    cmd_wr                       = cmd_q;
    cmd_wr[3'(CMD_SRST)]         = 1'b0;
    status_clr                   = rsp_status_q;
    status_clr[5'(STATUS_DONE)]  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d           = req_op_a;
          b_d           = req_op_b;
          cmd_d         = req_cmd;
          poll_cnt_d    = '0;
          rsp_timeout_d = 1'b0;
          state_d       = S_WR_A;
        end
      end
      S_WR_A:   state_d = S_WR_B;
      S_WR_B:   state_d = S_WR_CMD;
      S_WR_CMD: state_d = S_GAP;
      S_GAP:    state_d = S_POLL;
      S_POLL: begin
        if (rd_last_c) begin
          rsp_status_d = rd_data_c;
          poll_cnt_d   = poll_cnt_q + POLL_CNT_W'(1);
          // Done wins over the poll limit when both happen on the same poll
          if (rd_data_c[5'(STATUS_DONE)]) begin
            state_d = S_GAP2;
          end else if (poll_cnt_d == POLL_CNT_W'(POLL_MAX)) begin
            state_d = S_ABORT;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP2:   state_d = S_RD_RES;
      S_RD_RES: begin
        if (rd_last_c) begin
          rsp_result_d = rd_data_c;
          state_d      = S_CLR;
        end
      end
      S_CLR:    state_d = S_RESP;
      S_ABORT: begin
        rsp_timeout_d = 1'b1;
        rsp_result_d  = '0;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase

    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    rsp_valid_d   = (state_d == S_RESP);
    sw_read_en_d  = 1'b0;
    sw_write_en_d = 1'b0;
    sw_address_d  = '0;
    sw_datain_d   = '0;

    case (state_d)
      S_WR_A: begin
        sw_write_en_d = 1'b1;
        sw_address_d  = ADDR_OPA;
        sw_datain_d   = a_d;
      end
      S_WR_B: begin
        sw_write_en_d = 1'b1;
        sw_address_d  = ADDR_OPB;
        sw_datain_d   = b_q;
      end
      S_WR_CMD: begin
        sw_write_en_d = 1'b1;
        sw_address_d  = ADDR_CMD;
        sw_datain_d   = DATA_W'(cmd_wr);
      end
      S_CLR: begin
        sw_write_en_d = 1'b1;
        sw_address_d  = ADDR_STATUS;
        sw_datain_d   = status_clr;
      end
      S_ABORT: begin
        sw_write_en_d                 = 1'b1;
        sw_address_d                  = ADDR_CMD;
        sw_datain_d[5'(CMD_SRST)]     = 1'b1;
      end
      S_POLL: begin
        sw_read_en_d = 1'b1;
        sw_address_d = ADDR_STATUS;
      end
      S_RD_RES: begin
        sw_read_en_d = 1'b1;
        sw_address_d = ADDR_RESULT;
      end
      default: ;
    endcase
  end

  // State, job and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      cmd_q         <= '0;
      poll_cnt_q    <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_status_q  <= '0;
      rsp_timeout_q <= 1'b0;
      sw_read_en_q  <= 1'b0;
      sw_write_en_q <= 1'b0;
      sw_address_q  <= '0;
      sw_datain_q   <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cmd_q         <= cmd_d;
      poll_cnt_q    <= poll_cnt_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_status_q  <= rsp_status_d;
      rsp_timeout_q <= rsp_timeout_d;
      sw_read_en_q  <= sw_read_en_d;
      sw_write_en_q <= sw_write_en_d;
      sw_address_q  <= sw_address_d;
      sw_datain_q   <= sw_datain_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_timeout = rsp_timeout_q;
  assign sw_read_en  = sw_read_en_q;
  assign sw_write_en = sw_write_en_q;
  assign sw_address  = sw_address_q;
  assign sw_datain   = sw_datain_q;

endmodule

// File: tb/tb_fpu_host_sequencer.sv
// Bench for fpu_host_sequencer: a behavioural model of the FPU register block
// answers the bus, and each job is scored against values derived from the job.
module tb_fpu_host_sequencer;

  localparam int unsigned L    = 4;
  localparam int unsigned PMAX = 4;

  localparam logic [31:0] A_CMD    = 32'h000;
  localparam logic [31:0] A_OPA    = 32'h010;
  localparam logic [31:0] A_OPB    = 32'h050;
  localparam logic [31:0] A_STATUS = 32'h110;
  localparam logic [31:0] A_RESULT = 32'h130;

  logic        clk, reset_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_timeout, busy;
  logic        sw_read_en, sw_write_en;
  logic [31:0] req_op_a, req_op_b, rsp_result, rsp_status;
  logic [31:0] sw_address, sw_datain, sw_dataout;
  logic [7:0]  req_cmd;

  int n_checks, n_fail, cyc;

  // FPU register block model state
  logic        m_done;
  int          m_cnt, job_d;
  logic [30:0] stat_hi;
  logic [31:0] m_opa, m_opb, m_res;
  logic [7:0]  m_cmd;
  logic        prev_re, skip_hold;
  int          rd_hold, status_reads;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  fpu_host_sequencer #(.READ_LAT(L), .POLL_MAX(PMAX)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op_a    (req_op_a),
    .req_op_b    (req_op_b),
    .req_cmd     (req_cmd),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_status  (rsp_status),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .sw_address  (sw_address),
    .sw_read_en  (sw_read_en),
    .sw_write_en (sw_write_en),
    .sw_datain   (sw_datain),
    .sw_dataout  (sw_dataout)
  );

  function automatic logic [31:0] res_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [7:0] c);
    return (a + {b[15:0], b[31:16]}) ^ {24'h0, c};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Register block model, evaluated mid-cycle while the bus is stable
  always @(negedge clk) begin
    check_eq("rw_exclusive", 64'(sw_read_en & sw_write_en), 64'(0));
    if (!sw_read_en && !sw_write_en)
      check_eq("idle_bus", {sw_address, sw_datain}, 64'(0));
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_res  = res_fn(m_opa, m_opb, m_cmd);
      end
    end
    if (sw_write_en) begin
      wr_addr_q.push_back(sw_address);
      wr_data_q.push_back(sw_datain);
      case (sw_address)
        A_OPA: m_opa = sw_datain;
        A_OPB: m_opb = sw_datain;
        A_CMD: begin
          if (sw_datain[0]) begin
            m_done = 1'b0; m_cnt = 0; m_res = 32'h0;
          end else begin
            m_cmd = sw_datain[7:0]; m_done = 1'b0; m_cnt = job_d;
          end
        end
        A_STATUS: m_done = sw_datain[0];
        default: ;
      endcase
    end
    if (sw_read_en) begin
      rd_hold = prev_re ? rd_hold + 1 : 0;
      if (!prev_re && sw_address == A_STATUS) status_reads++;
    end else if (prev_re && !skip_hold) begin
      check_eq("rd_hold", 64'(rd_hold + 1), 64'(L));
    end
    prev_re = sw_read_en;
    if (sw_read_en && rd_hold == int'(L) - 1) begin
      case (sw_address)
        A_STATUS: sw_dataout = {stat_hi, m_done};
        A_RESULT: sw_dataout = m_res;
        default:  sw_dataout = 32'h0;
      endcase
    end else begin
      sw_dataout = 32'hDEAD_BEEF;
    end
  end

  // One full job; d = cycles from the CMD write until the model raises done
  task automatic run_job(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] c, input int d, input int stall);
    int          acc_edge, kdone, polls, exp_lat, n;
    bit          tmo, got;
    logic [31:0] exp_res, exp_stat;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    acc_edge = 0;
    kdone    = (d + int'(L)) / int'(L + 1);
    tmo      = (kdone > int'(PMAX));
    polls    = tmo ? int'(PMAX) : kdone;
    exp_lat  = tmo ? 4 + polls * int'(L + 1) : 6 + 2 * int'(L) + (polls - 1) * int'(L + 1);
    stat_hi  = 31'($urandom);
    exp_stat = {stat_hi, ~tmo};
    exp_res  = tmo ? 32'h0 : res_fn(a, b, {c[7:1], 1'b0});
    ea = '{A_OPA, A_OPB, A_CMD, tmo ? A_CMD : A_STATUS};
    ed = '{a, b, {24'h0, c[7:1], 1'b0}, tmo ? 32'h1 : {stat_hi, 1'b0}};
    job_d = d;
    wr_addr_q.delete();
    wr_data_q.delete();
    status_reads = 0;

    @(negedge clk);
    req_op_a = a; req_op_b = b; req_cmd = c; req_valid = 1'b1;
    rsp_ready = (stall == 0);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      if (req_ready) begin got = 1; acc_edge = cyc + 1; end
      else @(negedge clk);
    end
    check_eq({name, "_accept"}, 64'(got), 64'(1));
    @(negedge clk);
    // A second offer while busy must be ignored
    req_op_a = $urandom; req_op_b = $urandom; req_cmd = 8'($urandom);
    check_eq({name, "_busy"}, 64'(busy), 64'(1));
    check_eq({name, "_ready_low"}, 64'(req_ready), 64'(0));
    got = 0;
    for (int t = 0; t < 2000 && !got; t++) begin
      if (rsp_valid) got = 1;
      else @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq({name, "_rsp_seen"}, 64'(got), 64'(1));
    check_eq({name, "_latency"}, 64'(cyc - acc_edge), 64'(exp_lat));
    for (int i = 0; i < stall; i++) begin
      check_eq({name, "_hold_valid"}, 64'(rsp_valid), 64'(1));
      check_eq({name, "_hold_result"}, 64'(rsp_result), 64'(exp_res));
      check_eq({name, "_hold_ready"}, 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check_eq({name, "_result"}, 64'(rsp_result), 64'(exp_res));
    check_eq({name, "_status"}, 64'(rsp_status), 64'(exp_stat));
    check_eq({name, "_timeout"}, 64'(rsp_timeout), 64'(tmo));
    check_eq({name, "_polls"}, 64'(status_reads), 64'(polls));
    n = wr_addr_q.size();
    check_eq({name, "_wr_count"}, 64'(n), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        check_eq({name, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(ea[i]));
        check_eq({name, "_wr_data"}, 64'(wr_data_q[i]), 64'(ed[i]));
      end
    end
    @(negedge clk);
    check_eq({name, "_consumed"}, 64'(rsp_valid), 64'(0));
    check_eq({name, "_idle_ready"}, 64'(req_ready), 64'(1));
    rsp_ready = 1'b0;
  endtask

  // Start a job that never completes and pull reset while it is polling
  task automatic reset_mid_poll();
    bit got;
    stat_hi   = 31'($urandom);
    job_d     = 1000;
    skip_hold = 1'b1;
    @(negedge clk);
    req_op_a = $urandom; req_op_b = $urandom; req_cmd = 8'h10;
    req_valid = 1'b1; rsp_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      if (req_ready) got = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      if (sw_read_en) got = 1;
      else @(negedge clk);
    end
    check_eq("rst_reached_poll", 64'(got), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_read_en", 64'(sw_read_en), 64'(0));
    check_eq("rst_address", 64'(sw_address), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_req_ready", 64'(req_ready), 64'(1));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_no_rsp", 64'(rsp_valid), 64'(0));
    check_eq("rst_idle", 64'(busy), 64'(0));
    rsp_ready = 1'b0;
    skip_hold = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b1; cyc = 0;
    n_checks = 0; n_fail = 0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_op_a = 32'h0; req_op_b = 32'h0; req_cmd = 8'h0;
    m_done = 1'b0; m_cnt = 0; job_d = 1; stat_hi = 31'h0;
    m_opa = 32'h0; m_opb = 32'h0; m_res = 32'h0; m_cmd = 8'h0;
    prev_re = 1'b0; skip_hold = 1'b0; rd_hold = 0; status_reads = 0;
    sw_dataout = 32'h0;
    #1 reset_n = 1'b0;
    #2;
    check_eq("reset_req_ready", 64'(req_ready), 64'(1));
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_rsp", {rsp_result, 30'h0, rsp_valid, rsp_timeout}, 64'(0));
    check_eq("reset_status", 64'(rsp_status), 64'(0));
    check_eq("reset_strobes", {62'h0, sw_read_en, sw_write_en}, 64'(0));
    check_eq("reset_bus", {sw_address, sw_datain}, 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_job("nominal", 32'h2644D2E7, 32'hA6105F54, 8'h46, 3, 0);
    run_job("cmd_bit0", 32'h1234_5678, 32'h0BAD_F00D, 8'h47, 3, 0);
    run_job("slow", 32'hCAFE_0001, 32'h0000_FFFF, 8'h22, 12, 0);
    run_job("done_at_max", 32'h7777_0000, 32'h1111_2222, 8'h08, 18, 0);
    run_job("timeout", 32'hFFFF_FFFF, 32'h0000_0001, 8'h80, 1000, 0);
    run_job("backpressure", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 8'h3C, 5, 10);
    reset_mid_poll();
    run_job("after_reset", 32'h8000_0000, 32'h0000_8000, 8'hE2, 4, 0);
    for (int j = 0; j < 10; j++) begin
      run_job("random", $urandom, $urandom, 8'($urandom),
              int'($urandom_range(25, 1)), int'($urandom_range(3, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_host_sequencer.md
# fpu_host_sequencer

Register-bus initiator for the decimal FPU `top` block. It accepts one operation job (operand A, operand B, command byte) on a valid/ready port. It then drives the `sw_*` software register interface of `top`: writes the operands and command, polls the status register, reads the result and clears the done flag. The result is returned on a valid/ready response port. It sits between a processor/DMA front end and `top`, replacing hand-driven register traffic.

## Interface
- `READ_LAT`, 4, cycles `sw_read_en`/`sw_address` are held per read; `sw_dataout` is sampled on the last of them
- `POLL_MAX`, 64, status polls without done before the job is aborted (8-bit poll counter; `POLL_MAX` must be ≤255)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  job offered
- `req_ready`  out  1  job accepted when both high
- `req_op_a`  in  32  operand A
- `req_op_b`  in  32  operand B
- `req_cmd`  in  8  command byte written to CMD[7:0]; bit0 (soft reset) is forced to 0
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed when both high
- `rsp_result`  out  32  result word
- `rsp_status`  out  32  last status word read
- `rsp_timeout`  out  1  job aborted after `POLL_MAX` polls
- `busy`  out  1  high in every state except IDLE
- `sw_address`  out  32  register address
- `sw_read_en`  out  1  read strobe
- `sw_write_en`  out  1  write strobe, captured by `top` on rising edge
- `sw_datain`  out  32  write data
- `sw_dataout`  in  32  read data

## Operation
- Register map: CMD 0x000, OPA 0x010, OPB 0x050, STATUS 0x110, RESULT 0x130. STATUS bit0 = done. CMD bit0 = soft reset (self-clearing in `top`).
- FSM states: IDLE → WR_A → WR_B → WR_CMD → GAP → POLL → (done ? GAP2 → RD_RES : GAP → POLL) → CLR → RESP → IDLE.
- Abort path: POLL with count = `POLL_MAX` and no done → ABORT → RESP.
- IDLE: `req_ready`=1. On handshake, latch A, B and cmd, clear the poll counter, go to WR_A.
- WR_A/WR_B/WR_CMD: each is one cycle with `sw_write_en`=1 and the corresponding address and data. CMD data = {24'h0, req_cmd[7:1], 1'b0}.
- GAP/GAP2: one turnaround cycle, both strobes low.
- POLL: `sw_read_en`=1 at STATUS for `READ_LAT` cycles. On the last cycle, latch `sw_dataout` into `rsp_status` and increment the poll counter.
- RD_RES: `sw_read_en`=1 at RESULT for `READ_LAT` cycles; latch `rsp_result` on the last cycle.
- CLR: one-cycle write to STATUS with data = `rsp_status` & 32'hFFFF_FFFE.
- ABORT: one-cycle write to CMD with data = 32'h0000_0001. Then `rsp_timeout`=1 and `rsp_result`=0.
- RESP: hold `rsp_valid` and the response fields stable until `rsp_ready`; then go to IDLE with `rsp_valid`=0.
- `sw_read_en` and `sw_write_en` are never high together. Address and data are 0 whenever both strobes are low.

## Timing
- Reset values:
  - `req_ready`=1
  - `busy`=0
  - `rsp_valid`=0, `rsp_result`=0, `rsp_status`=0, `rsp_timeout`=0
  - `sw_read_en`=0, `sw_write_en`=0, `sw_address`=0, `sw_datain`=0
- Outputs are registered or pure state decodes. There is no combinational path from `sw_dataout` or `rsp_ready` to any output.
- Best-case latency (done on first poll): `rsp_valid` rises 6+2·`READ_LAT` edges after the accepting edge (14 for `READ_LAT`=4).
- Each extra poll adds `READ_LAT`+1 cycles.
- `req_valid` while busy is ignored (`req_ready`=0). There is no queueing.
- `rsp_ready` held high before RESP: the response is consumed in its first cycle, and IDLE follows one cycle later.
- Async reset mid-operation: strobes drop immediately and the FSM returns to IDLE. The job is lost and no response is issued.
- A done bit seen in the same poll that reaches `POLL_MAX` counts as done, not timeout.

## Structure
- Package `fpu_host_pkg`: the register address constants, the STATUS_DONE and CMD_SRST bit indices, and the FSM state enum.
- One sub-module is natural: `sw_read_port`. It holds a read strobe for `READ_LAT` cycles and pulses `data_valid` with captured data. POLL and RD_RES share it.

## Test plan
- Nominal: A=32'h2644D2E7, B=32'hA6105F54, cmd=8'h46. The bus model sets done after 3 cycles → writes 0x010, 0x050, then 0x000 with data 0x46. `rsp_valid` arrives at edge 14 with the model's result, and STATUS is written with the done bit cleared.
- Slow core: done appears on the 3rd poll → exactly 3 STATUS reads, and `rsp_valid` arrives at edge 14+2·5=24.
- Timeout with `POLL_MAX`=4: done never set → 4 polls, then CMD write 32'h1, then `rsp_timeout`=1 and `rsp_result`=0.
- Command bit0 forced: `req_cmd`=8'h47 → CMD written as 32'h46.
- Backpressure: `rsp_ready`=0 for 10 cycles → response fields stable, `req_ready`=0 throughout. The next job is accepted the cycle after the handshake.
- Reset mid-POLL: `reset_n` pulsed low → `sw_read_en`=0 asynchronously. After release, a new job completes normally.
